fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL provide: stall input 1, hazard unit holds F and D stages.
REQ-003 SHALL provide: instr_d input 32, instruction in D stage.
REQ-004 SHALL provide: pc_d input 32, PC of instr_d.
REQ-005 SHALL provide: cmp_jump input 1, branch condition result for instr_d from the D-stage comparator.
REQ-006 SHALL provide: rs_d input 32, forwarded GPR[rs] for jr/jalr.
REQ-007 SHALL provide: exc_req input 1, exception/interrupt taken this cycle; eret_req input 1, eret committing; epc input 32, return address.
REQ-008 SHALL provide: pc_f output 32, fetch address; fetch_valid output 1, pc_f holds a real fetch.
REQ-009 SHALL provide: link_addr output 32, pc_d+8 for jal/jalr; adel_f output 1, fetch address fault; flush_d output 1, squash the D-stage instruction.

Function
REQ-010 SHALL decode instr_d: branch = opcode 0x04-0x07, or opcode 0x01 with rt 0x00/0x01; j = 0x02; jal = 0x03; jr = opcode 0 func 0x08; jalr = opcode 0 func 0x09.
REQ-011 SHALL assert redirect when (branch AND cmp_jump) OR j OR jal OR jr OR jalr.
REQ-012 SHALL compute branch target = pc_d + 4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-013 SHALL compute j/jal target = {pc_d+4 [31:28], instr_d[25:0], 2'b00}; jr/jalr target = rs_d unmodified.
REQ-014 SHALL select next PC by priority: eret_req -> epc; exc_req -> 0x0000_4180; stall -> hold pc_f; redirect -> target; else pc_f+4.
REQ-015 SHALL let eret_req and exc_req override stall; if both are asserted, eret_req wins.
REQ-016 SHALL update pc_f on the clock edge after the selecting cycle (one-cycle latency, no bubbles inserted by this block).
REQ-017 SHALL drive link_addr = pc_d + 8 combinationally, independent of stall.
REQ-018 SHALL assert adel_f combinationally when pc_f[1:0] != 0 or pc_f is outside 0x0000_3000..0x0000_6FFC inclusive; pc_f still advances normally.
REQ-019 SHALL implement FSM states S_RST, S_RUN, S_HOLD.
REQ-020 S_RST SHALL be entered on reset and held for one cycle with fetch_valid=0, then go to S_RUN.
REQ-021 S_RUN SHALL go to S_HOLD when stall=1 and no eret_req/exc_req; fetch_valid=1.
REQ-022 S_HOLD SHALL hold pc_f with fetch_valid=1, and SHALL return to S_RUN when stall=0 or when eret_req/exc_req arrives (PC loaded that edge).
REQ-023 SHALL wrap pc_f+4 from 0xFFFF_FFFC to 0x0000_0000, and SHALL raise adel_f on that address.

Reset
REQ-024 SHALL on reset set pc_f=0x0000_3000, state=S_RST, fetch_valid=0, flush_d=0; reset SHALL override stall, exc_req and eret_req.
REQ-025 SHALL, on reset asserted mid-redirect, discard the redirect and restart at 0x0000_3000.

Configuration
REQ-026 SHALL use macro DELAY_SLOT_EN.
REQ-027 With DELAY_SLOT_EN defined, the instruction after a redirecting instruction (delay slot) executes, and flush_d SHALL be tied 0.
REQ-028 Without DELAY_SLOT_EN, flush_d SHALL be 1 on the cycle redirect=1 and stall=0, so the wrong-path fetched instruction is squashed; jal/jalr link stays pc_d+8.

Verification
REQ-029 Reset sequence: assert reset 2 cycles, then release -> pc_f=0x3000, fetch_valid=0 for one cycle; next edges give pc_f 0x3004, 0x3008.
REQ-030 Branch taken: instr_d=beq imm 0x0003, pc_d=0x3004, cmp_jump=1 -> next pc_f=0x3014 (delay-slot build, flush_d=0); no-delay-slot build -> flush_d=1 that cycle.
REQ-031 Branch not taken and stall: bne with cmp_jump=0 -> pc_f+4; with stall=1 for 3 cycles -> pc_f constant, state S_HOLD, then resumes.
REQ-032 Exception during stall: stall=1, exc_req=1 -> next pc_f=0x4180; eret_req=1 with epc=0x3010 same cycle -> 0x3010.
REQ-033 Jump register: jr with rs_d=0x0000_3002 -> pc_f=0x3002, adel_f=1.
REQ-034 jalr: jalr at pc_d=0x3020 -> link_addr=0x3028.

Source files
------------

// File: rtl/fetch_pc_if.sv
// rtl/fetch_pc_if.sv - fetch-stage PC control bundle between pipeline/hazard logic and fetch_pc
interface fetch_pc_if;
    logic        stall;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        cmp_jump;
    logic [31:0] rs_d;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic        fetch_valid;
    logic [31:0] link_addr;
    logic        adel_f;
    logic        flush_d;

    modport master (
        output stall, instr_d, pc_d, cmp_jump, rs_d, exc_req, eret_req, epc,
        input  pc_f, fetch_valid, link_addr, adel_f, flush_d
    );

    modport slave (
        input  stall, instr_d, pc_d, cmp_jump, rs_d, exc_req, eret_req, epc,
        output pc_f, fetch_valid, link_addr, adel_f, flush_d
    );
endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - fetch PC sequencer with D-stage branch/jump resolution; DELAY_SLOT_EN keeps delay slots (no D flush)
module fetch_pc (
    input  logic       clk,
    input  logic       reset,
    fetch_pc_if.slave  fp
);
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;

    typedef enum logic [1:0] {S_RST, S_RUN, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        fetch_valid_q;

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic        is_branch, is_j, is_jal, is_jr, is_jalr;
    logic        redirect;
    logic [31:0] pc_plus4_d;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;
    logic        trap;

    assign opcode = fp.instr_d[31:26];
    assign rt     = fp.instr_d[20:16];
    assign func   = fp.instr_d[5:0];
    assign imm    = fp.instr_d[15:0];

    always_comb begin
        is_branch = (opcode >= 6'h04 && opcode <= 6'h07) ||
                    (opcode == 6'h01 && (rt == 5'h00 || rt == 5'h01));
        is_j      = (opcode == 6'h02);
        is_jal    = (opcode == 6'h03);
        is_jr     = (opcode == 6'h00) && (func == 6'h08);
        is_jalr   = (opcode == 6'h00) && (func == 6'h09);
        redirect  = (is_branch && fp.cmp_jump) || is_j || is_jal || is_jr || is_jalr;
    end

    assign pc_plus4_d    = fp.pc_d + 32'd4;
    assign branch_target = pc_plus4_d + {{14{imm[15]}}, imm, 2'b00};
    assign jump_target   = {pc_plus4_d[31:28], fp.instr_d[25:0], 2'b00};

    always_comb begin
        redirect_target = branch_target;
        if (is_j || is_jal)
            redirect_target = jump_target;
        else if (is_jr || is_jalr)
            redirect_target = fp.rs_d;
    end

    // Trap returns and traps outrank the hazard hold; eret beats a coincident exception.
    assign trap = fp.eret_req || fp.exc_req;

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (fp.eret_req)
            next_pc = fp.epc;
        else if (fp.exc_req)
            next_pc = EXC_VECTOR;
        else if (fp.stall)
            next_pc = pc_q;
        else if (redirect)
            next_pc = redirect_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_RST;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
        end else begin
            pc_q          <= next_pc;
            fetch_valid_q <= 1'b1;
            case (state)
                S_RST:   state <= S_RUN;
                S_RUN:   state <= (fp.stall && !trap) ? S_HOLD : S_RUN;
                S_HOLD:  state <= (!fp.stall || trap) ? S_RUN : S_HOLD;
                default: state <= S_RST;
            endcase
        end
    end

    assign fp.pc_f        = pc_q;
    assign fp.fetch_valid = fetch_valid_q;
    assign fp.link_addr   = fp.pc_d + 32'd8;
    assign fp.adel_f      = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

`ifdef DELAY_SLOT_EN
    assign fp.flush_d = 1'b0;
`else
    // The sequential fetch behind a taken redirect is wrong-path; squash it as it lands in D.
    assign fp.flush_d = redirect && !fp.stall && !reset;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - directed plus randomized check of fetch_pc against a behavioural PC model
module tb_fetch_pc;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_pc;
    bit          m_fv;

    fetch_pc_if bus ();

    fetch_pc dut (
        .clk   (clk),
        .reset (reset),
        .fp    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_redirect(input logic [31:0] ins, input bit cmp);
        int unsigned op, rt, fn;
        op = ins >> 26;
        rt = (ins >> 16) & 31;
        fn = ins & 63;
        if (op >= 4 && op <= 7) return cmp;
        if (op == 1 && rt <= 1) return cmp;
        if (op == 2 || op == 3) return 1'b1;
        if (op == 0 && (fn == 8 || fn == 9)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] ins, input logic [31:0] pcd,
                                               input logic [31:0] rs);
        int unsigned op;
        logic [31:0] off;
        op = ins >> 26;
        if (op == 2 || op == 3) return ((pcd + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (op == 0) return rs;
        off = 32'(int'($signed(ins[15:0])) * 4);
        return pcd + 32'd4 + off;
    endfunction

    function automatic bit ref_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    task automatic set_in(input bit st, input logic [31:0] ins, input logic [31:0] pcd, input bit cmp,
                          input logic [31:0] rs, input bit exc, input bit eret, input logic [31:0] ep);
        bus.stall    = st;
        bus.instr_d  = ins;
        bus.pc_d     = pcd;
        bus.cmp_jump = cmp;
        bus.rs_d     = rs;
        bus.exc_req  = exc;
        bus.eret_req = eret;
        bus.epc      = ep;
    endtask

    task automatic tick(input string tag);
        logic [31:0] nxt;
        bit rd, exp_fl;
        #1;
        rd = ref_redirect(bus.instr_d, bus.cmp_jump);
        check({tag, "_link"}, bus.link_addr, bus.pc_d + 32'd8);
        check({tag, "_adel"}, {31'b0, bus.adel_f}, {31'b0, ref_adel(m_pc)});
`ifdef DELAY_SLOT_EN
        exp_fl = 1'b0;
`else
        exp_fl = rd && !bus.stall && !reset;
`endif
        check({tag, "_flush"}, {31'b0, bus.flush_d}, {31'b0, exp_fl});
        if (reset)             nxt = 32'h3000;
        else if (bus.eret_req) nxt = bus.epc;
        else if (bus.exc_req)  nxt = 32'h4180;
        else if (bus.stall)    nxt = m_pc;
        else if (rd)           nxt = ref_target(bus.instr_d, bus.pc_d, bus.rs_d);
        else                   nxt = m_pc + 32'd4;
        @(posedge clk);
        m_pc = nxt;
        m_fv = !reset;
        #1;
        check({tag, "_pc"}, bus.pc_f, m_pc);
        check({tag, "_fv"}, {31'b0, bus.fetch_valid}, {31'b0, m_fv});
    endtask

    initial begin
        logic [31:0] ins;
        reset = 1'b1;
        set_in(1'b1, 32'h0, 32'h3000, 1'b1, 32'h0, 1'b1, 1'b1, 32'h5000);
        repeat (2) @(posedge clk);
        #1;
        m_pc = 32'h3000;
        m_fv = 1'b0;
        check("rst_pc", bus.pc_f, 32'h3000);
        check("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
        check("rst_flush", {31'b0, bus.flush_d}, 32'h0);

        reset = 1'b0;
        set_in(1'b0, 32'h0, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("seq1");
        check("seq_3004", bus.pc_f, 32'h3004);
        tick("seq2");
        check("seq_3008", bus.pc_f, 32'h3008);

        set_in(1'b0, 32'h1000_0003, 32'h3004, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("beq");
        check("beq_target", bus.pc_f, 32'h3014);

        set_in(1'b0, 32'h1400_0005, 32'h3010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("bne_nt");
        check("bne_seq", bus.pc_f, 32'h3018);

        set_in(1'b1, 32'h0, 32'h3014, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick("stall");
        check("stall_hold", bus.pc_f, 32'h3018);
        set_in(1'b0, 32'h0, 32'h3014, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("resume");
        check("resume_pc", bus.pc_f, 32'h301C);

        set_in(1'b1, 32'h0, 32'h3018, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick("exc_stall");
        check("exc_vector", bus.pc_f, 32'h4180);
        set_in(1'b1, 32'h0, 32'h3018, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3010);
        tick("eret_exc");
        check("eret_epc", bus.pc_f, 32'h3010);

        set_in(1'b0, 32'h0080_0008, 32'h300C, 1'b0, 32'h3002, 1'b0, 1'b0, 32'h0);
        tick("jr");
        check("jr_pc", bus.pc_f, 32'h3002);
        check("jr_adel", {31'b0, bus.adel_f}, 32'h1);

        set_in(1'b0, 32'h0080_0009, 32'h3020, 1'b0, 32'h3000, 1'b0, 1'b0, 32'h0);
        #1;
        check("jalr_link", bus.link_addr, 32'h3028);
        tick("jalr");

        set_in(1'b0, 32'h0080_0008, 32'h3000, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick("jr_top");
        set_in(1'b0, 32'h0, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("wrap");
        check("wrap_pc", bus.pc_f, 32'h0);
        check("wrap_adel", {31'b0, bus.adel_f}, 32'h1);

        set_in(1'b0, 32'h0800_0100, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        tick("rst_redir");
        check("rst_redir_pc", bus.pc_f, 32'h3000);
        reset = 1'b0;
        set_in(1'b0, 32'h0, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("rst_after");

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 7))
                0: ins[31:26] = 6'($urandom_range(4, 7));
                1: begin ins[31:26] = 6'h01; ins[20:17] = 4'h0; end
                2: ins[31:26] = 6'h02;
                3: ins[31:26] = 6'h03;
                4: begin ins[31:26] = 6'h00; ins[5:0] = 6'h08; end
                5: begin ins[31:26] = 6'h00; ins[5:0] = 6'h09; end
                default: ;
            endcase
            set_in($urandom_range(0, 9) < 3, ins,
                   ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095),
                   1'($urandom),
                   ($urandom_range(0, 1) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095),
                   $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                   32'h3000 + 4 * $urandom_range(0, 4095));
            reset = ($urandom_range(0, 49) == 0);
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
